// File: rtl/execute_writeback_stage.sv
// ============================================================================
// Module   : execute_writeback_stage
// Purpose  : XM23 execute stage. ALU plus PSW flag generation, the E/W pipeline
//            register, the register-file write port and the decode forwarding tap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_writeback_stage #(
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ex_valid,
    input  logic [3:0]              ex_op,
    input  logic                    ex_byte,
    input  logic [$clog2(NREG)-1:0] ex_dst_reg,
    input  logic [DW-1:0]           src_val,
    input  logic [DW-1:0]           dst_val,
    input  logic                    carry_val,
    input  logic                    stall,
    input  logic                    flush,
    output logic                    wb_we,
    output logic [$clog2(NREG)-1:0] wb_reg,
    output logic [DW-1:0]           wb_data,
    output logic                    psw_we,
    output logic [3:0]              psw_vnzc,
    output logic                    fwd_valid,
    output logic [$clog2(NREG)-1:0] fwd_reg,
    output logic [DW-1:0]           fwd_data
);

    localparam int RW   = $clog2(NREG);
    localparam int NNIB = DW / 4;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDC = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SUBC = 4'd3;
    localparam logic [3:0] OP_DADD = 4'd4;
    localparam logic [3:0] OP_CMP  = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_BIT  = 4'd9;
    localparam logic [3:0] OP_BIC  = 4'd10;
    localparam logic [3:0] OP_BIS  = 4'd11;
    localparam logic [3:0] OP_MOV  = 4'd12;
    localparam logic [3:0] OP_SRA  = 4'd13;
    localparam logic [3:0] OP_RRC  = 4'd14;
    localparam logic [3:0] OP_SXT  = 4'd15;

    // Binary adder path shared by ADD/ADDC/SUB/SUBC/CMP
    logic          is_sub;
    logic          add_cin;
    logic [DW-1:0] b_eff;
    logic [DW:0]   sum_w;
    logic          add_c;
    logic          add_v;

    // BCD adder path
    logic [DW-1:0] dec_res;
    logic [NNIB:0] dec_cy;
    logic [5:0]    dec_nib;

    // Result selection
    logic          byte_eff;
    logic [DW-1:0] res;
    logic          res_c;
    logic          res_v;
    logic          res_n;
    logic          res_z;
    logic [DW-1:0] merged;
    logic          op_writes;
    logic          op_flags;

    // E/W pipeline register
    logic          ew_valid;
    logic          ew_writes;
    logic          ew_flags;
    logic [RW-1:0] ew_reg;
    logic [DW-1:0] ew_data;
    logic [3:0]    ew_vnzc;

    assign is_sub  = (ex_op == OP_SUB) || (ex_op == OP_SUBC) || (ex_op == OP_CMP);
    assign b_eff   = is_sub ? ~src_val : src_val;
    assign add_cin = ((ex_op == OP_ADDC) || (ex_op == OP_SUBC)) ? carry_val :
                     ((ex_op == OP_SUB)  || (ex_op == OP_CMP));
    assign sum_w   = {1'b0, dst_val} + {1'b0, b_eff} + {{DW{1'b0}}, add_cin};
    // Carry into bit 8 recovered from the full-width sum: no separate byte adder
    assign add_c   = ex_byte ? (sum_w[8] ^ dst_val[8] ^ b_eff[8]) : sum_w[DW];
    assign add_v   = ex_byte ?
        ((dst_val[7] == b_eff[7]) && (sum_w[7] != dst_val[7])) :
        ((dst_val[DW-1] == b_eff[DW-1]) && (sum_w[DW-1] != dst_val[DW-1]));

    // BCD ripple: each nibble above 9 is corrected by +6 and carries on.
    // The chain starts with no carry-in; PSW.C does not enter DADD.
    always_comb begin
        dec_res = '0;
        dec_cy  = '0;
        dec_nib = '0;
        for (int i = 0; i < NNIB; i++) begin
            dec_nib = {2'b00, dst_val[i*4 +: 4]} + {2'b00, src_val[i*4 +: 4]}
                    + {5'b00000, dec_cy[i]};
            if (dec_nib > 6'd9) begin
                dec_nib     = dec_nib + 6'd6;
                dec_cy[i+1] = 1'b1;
            end else begin
                dec_cy[i+1] = 1'b0;
            end
            dec_res[i*4 +: 4] = dec_nib[3:0];
        end
    end

    // ALU result and raw C/V selection per opcode
    always_comb begin
        res   = '0;
        res_c = carry_val;
        res_v = 1'b0;
        case (ex_op)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: begin
                res   = sum_w[DW-1:0];
                res_c = add_c;
                res_v = add_v;
            end
            OP_DADD: begin
                res   = dec_res;
                res_c = ex_byte ? dec_cy[2] : dec_cy[NNIB];
            end
            OP_XOR:         res = dst_val ^ src_val;
            OP_AND, OP_BIT: res = dst_val & src_val;
            OP_OR,  OP_BIS: res = dst_val | src_val;
            OP_BIC:         res = dst_val & ~src_val;
            OP_MOV:         res = src_val;
            OP_SRA: begin
                res   = ex_byte ? {{(DW-8){1'b0}}, dst_val[7], dst_val[7:1]}
                                : {dst_val[DW-1], dst_val[DW-1:1]};
                res_c = dst_val[0];
            end
            OP_RRC: begin
                res   = ex_byte ? {{(DW-8){1'b0}}, carry_val, dst_val[7:1]}
                                : {carry_val, dst_val[DW-1:1]};
                res_c = dst_val[0];
            end
            OP_SXT:         res = {{(DW-8){dst_val[7]}}, dst_val[7:0]};
            default:        res = '0;
        endcase
    end

    // SXT is word-only, so the byte flag is ignored for it
    assign byte_eff  = ex_byte && (ex_op != OP_SXT);
    assign res_n     = byte_eff ? res[7] : res[DW-1];
    assign res_z     = byte_eff ? (res[7:0] == 8'h00) : (res == '0);
    assign merged    = byte_eff ? {dst_val[DW-1:8], res[7:0]} : res;
    assign op_writes = (ex_op != OP_CMP) && (ex_op != OP_BIT);
    assign op_flags  = (ex_op != OP_MOV) && (ex_op != OP_SXT);

    // E/W capture: stall holds everything (and beats flush); flush squashes valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ew_valid  <= 1'b0;
            ew_writes <= 1'b0;
            ew_flags  <= 1'b0;
            ew_reg    <= '0;
            ew_data   <= '0;
            ew_vnzc   <= 4'b0000;
        end else if (!stall) begin
            ew_valid  <= ex_valid && !flush;
            ew_writes <= op_writes;
            ew_flags  <= op_flags;
            ew_reg    <= ex_dst_reg;
            ew_data   <= merged;
            ew_vnzc   <= {res_v, res_n, res_z, res_c};
        end
    end

    assign wb_we     = ew_valid && ew_writes && !stall;
    assign wb_reg    = ew_reg;
    assign wb_data   = ew_data;
    assign psw_we    = ew_valid && ew_flags && !stall;
    assign psw_vnzc  = ew_vnzc;
    assign fwd_valid = ew_valid && ew_writes;
    assign fwd_reg   = ew_reg;
    assign fwd_data  = ew_data;

endmodule

`default_nettype wire
